// File: rtl/axi_llc_way_reader.sv
// Read initiator for one LLC data way. It issues one way read per beat of a descriptor
// and returns the responses in order through a credit-limited response FIFO.
module axi_llc_way_reader #(
    parameter int          SetAssociativity = 8,
    parameter int          IndexWidth       = 10,
    parameter int          BlockOffsetWidth = 3,
    parameter int          DataWidth        = 64,
    parameter int          MaxOutstanding   = 4,
    parameter logic [1:0]  UnitId           = 2'd3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        desc_valid_i,
    output logic                        desc_ready_o,
    input  logic [SetAssociativity-1:0] desc_way_ind_i,
    input  logic [IndexWidth-1:0]       desc_index_i,
    input  logic [BlockOffsetWidth-1:0] desc_offset_i,
    input  logic [BlockOffsetWidth-1:0] desc_len_i,
    output logic                        way_req_valid_o,
    input  logic                        way_req_ready_i,
    output logic [SetAssociativity-1:0] way_req_ind_o,
    output logic [IndexWidth-1:0]       way_req_index_o,
    output logic [BlockOffsetWidth-1:0] way_req_offset_o,
    output logic                        way_req_we_o,
    output logic [1:0]                  way_req_unit_o,
    input  logic                        way_rsp_valid_i,
    output logic                        way_rsp_ready_o,
    input  logic [DataWidth-1:0]        way_rsp_data_i,
    input  logic [1:0]                  way_rsp_unit_i,
    output logic                        data_valid_o,
    input  logic                        data_ready_i,
    output logic [DataWidth-1:0]        data_o,
    output logic                        data_last_o,
    output logic                        busy_o,
    output logic                        rsp_err_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [SetAssociativity-1:0] way_q, way_d;
    logic [IndexWidth-1:0]       index_q, index_d;
    logic [BlockOffsetWidth-1:0] offset_q, offset_d;
    logic [BlockOffsetWidth-1:0] len_q, len_d;
    logic [BlockOffsetWidth-1:0] issued_q, issued_d;
    logic [BlockOffsetWidth-1:0] deliver_q, deliver_d;
    logic [CntW-1:0]             outstanding_q, outstanding_d;
    logic [CntW-1:0]             pending_q, pending_d;
    logic [CntW-1:0]             fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
    logic                        rsp_err_q, rsp_err_d;
    logic [DataWidth-1:0]        mem_q [MaxOutstanding];

    logic req_hs, out_hs, rsp_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign desc_ready_o     = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    // Valid depends only on registered state, so it cannot drop before its handshake.
    assign way_req_valid_o  = (state_q == ISSUE) && (outstanding_q < MaxOut);
    assign way_req_ind_o    = way_q;
    assign way_req_index_o  = index_q;
    assign way_req_offset_o = offset_q + issued_q;
    assign way_req_we_o     = 1'b0;
    assign way_req_unit_o   = UnitId;
    assign way_rsp_ready_o  = !rst_i;
    assign data_valid_o     = (fifo_cnt_q != '0);
    assign data_o           = mem_q[rd_ptr_q];
    assign data_last_o      = data_valid_o && (state_q != IDLE) && (deliver_q == len_q);
    assign rsp_err_o        = rsp_err_q;

    assign req_hs = way_req_valid_o && way_req_ready_i;
    assign out_hs = data_valid_o && data_ready_i;
    assign rsp_ok = way_rsp_valid_i && (pending_q != '0) && (way_rsp_unit_i == UnitId);

    always_comb begin
        state_d   = state_q;
        way_d     = way_q;
        index_d   = index_q;
        offset_d  = offset_q;
        len_d     = len_q;
        issued_d  = issued_q;
        deliver_d = out_hs ? deliver_q + BlockOffsetWidth'(1) : deliver_q;
        rsp_err_d = way_rsp_valid_i && !rsp_ok;

        case (state_q)
            IDLE: begin
                if (desc_valid_i) begin
                    way_d     = desc_way_ind_i;
                    index_d   = desc_index_i;
                    offset_d  = desc_offset_i;
                    len_d     = desc_len_i;
                    issued_d  = '0;
                    deliver_d = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (req_hs) begin
                    issued_d = issued_q + BlockOffsetWidth'(1);
                    if (issued_q == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && data_last_o) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Credits are returned only when a beat leaves downstream, which bounds FIFO occupancy.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({req_hs, out_hs})
            2'b10:   outstanding_d = outstanding_q + CntW'(1);
            2'b01:   outstanding_d = outstanding_q - CntW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        pending_d = pending_q;
        case ({req_hs, rsp_ok})
            2'b10:   pending_d = pending_q + CntW'(1);
            2'b01:   pending_d = pending_q - CntW'(1);
            default: pending_d = pending_q;
        endcase

        fifo_cnt_d = fifo_cnt_q;
        case ({rsp_ok, out_hs})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        wr_ptr_d = rsp_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = out_hs ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            issued_q      <= '0;
            deliver_q     <= '0;
            outstanding_q <= '0;
            pending_q     <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            issued_q      <= issued_d;
            deliver_q     <= deliver_d;
            outstanding_q <= outstanding_d;
            pending_q     <= pending_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        way_q    <= way_d;
        index_q  <= index_d;
        offset_q <= offset_d;
        len_q    <= len_d;
        if (rsp_ok) mem_q[wr_ptr_q] <= way_rsp_data_i;
    end

endmodule
